// File: rtl/delay_pkg.sv
// ---------------------------------------------------------------------------
// delay_pkg
//
// Shared definitions for the reverb delay lines.
//   MAX_FILTER_FIFO_LENGTH : default buffer depth and longest delay, in words
//   ADDR_W                 : address width for a buffer of that depth
//   clamp_len()            : maps a signed requested delay onto 1..maxlen
// ---------------------------------------------------------------------------
package delay_pkg;

  localparam int MAX_FILTER_FIFO_LENGTH = 4096;
  localparam int ADDR_W                 = $clog2(MAX_FILTER_FIFO_LENGTH);

  // Effective delay length. Non-positive requests collapse to one sample,
  // because a zero-length delay would give a combinational path from input
  // to output inside the feedback loop. Requests beyond the buffer depth
  // saturate at the depth. The requested length arrives sign-extended to
  // 64 bits, so any data width up to 64 can use this function.
  function automatic logic [31:0] clamp_len(input logic signed [63:0] len,
                                            input logic        [31:0] maxlen);
    logic signed [63:0] max_s;
    max_s = signed'({32'd0, maxlen});
    if (len <= 64'sd0) begin
      return 32'd1;
    end else if (len > max_s) begin
      return maxlen;
    end else begin
      return len[31:0];
    end
  endfunction

endpackage

// File: rtl/sdp_bram.sv
// ---------------------------------------------------------------------------
// sdp_bram
//
// Simple dual-port RAM: one synchronous write port and one synchronous,
// registered read port on the same clock. Written so synthesis maps it onto
// a block RAM.
//
// Ports
//   clk      : clock for both ports
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable; rdata_o holds its value while low
//   raddr_i  : read address, sampled at the clock edge
//   rdata_o  : read data, valid one cycle after the address is sampled
//
// A read and a write to the same address in the same cycle return the old
// word. The delay line above never relies on that case; it bypasses it.
// ---------------------------------------------------------------------------
module sdp_bram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset. A reset would
  // stop block-RAM inference; the owner masks unwritten words instead.
  // NOTE: sequential state is assigned with <= only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_delay_bram.sv
// ---------------------------------------------------------------------------
// fifo_delay_bram
//
// Fixed-length sample delay line on a single block-RAM circular buffer.
// Each word captured on a sample tick reappears on `out` exactly L ticks
// later, where L is the clamped value of `len`. This is the delay element
// of the reverb all-pass and comb filters. Those filters close a feedback
// loop around it, so `out` is always registered and never a function of
// `in` within the same cycle.
//
// Ports
//   clk        : system clock, all state lives here
//   rstn       : asynchronous reset, ACTIVE-HIGH despite its name
//   sample_clk : sample-rate strobe, synchronous to clk; each rising edge
//                is one tick
//   enable     : ticks are ignored while low
//   len        : requested delay in samples, signed
//   in         : sample to store, signed
//   out        : delayed sample, registered, valid two clk cycles after
//                the tick and held until the next update
//
// Pipeline for a tick detected in cycle T:
//   end of T   : RAM write at wp, read address issued, bypass and zero-mask
//                decisions and the incoming word registered
//   T+1        : RAM read data available
//   end of T+1 : out updated
// ---------------------------------------------------------------------------
module fifo_delay_bram
  import delay_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MAXLEN = MAX_FILTER_FIFO_LENGTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sample_clk,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] len,
  input  logic signed [WIDTH-1:0] in,
  output logic signed [WIDTH-1:0] out
);

  // The address covers 0..MAXLEN-1. The length and fill counts need one
  // more bit to hold MAXLEN itself. The read-address sum needs two more
  // bits to hold wp + 1 + MAXLEN before it is reduced.
  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int LW = AW + 1;
  localparam int CW = AW + 2;

  // Edge detect and tick qualification.
  logic sc_q;
  logic tick;
  logic tick_en;

  // Circular-buffer bookkeeping.
  logic [AW-1:0] wp_q,   wp_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [LW-1:0] l_eff;
  logic [CW-1:0] ra_sum;
  logic [CW-1:0] ra_mod;
  logic [AW-1:0] ra;

  // Second pipeline stage: decisions made at the tick, applied one cycle
  // later when the RAM data arrive.
  logic                    upd_q;
  logic                    byp_q,  byp_d;
  logic                    zero_q, zero_d;
  logic signed [WIDTH-1:0] in_q;
  logic [WIDTH-1:0]        rd_data;
  logic signed [WIDTH-1:0] out_q,  out_d;

  // sc_q resets to 1, so a sample_clk that is already high when reset is
  // released is not mistaken for a rising edge.
  assign tick    = sample_clk & ~sc_q;
  assign tick_en = tick & enable;

  // The length is re-evaluated on every tick, so a new len applies from
  // the tick on which it is first seen.
  assign l_eff = LW'(clamp_len(64'(len), 32'(MAXLEN)));

  // ra = (wp + 1 - L) mod MAXLEN. MAXLEN is added first to keep the sum
  // non-negative. The sum then lies in 1..2*MAXLEN-1, so one conditional
  // subtract reduces it. A bit mask would only work for power-of-two depths.
  assign ra_sum = CW'(wp_q) + CW'(1) + CW'(MAXLEN) - CW'(l_eff);
  assign ra_mod = (ra_sum >= CW'(MAXLEN)) ? (ra_sum - CW'(MAXLEN)) : ra_sum;
  assign ra     = AW'(ra_mod);

  assign wp_d   = (wp_q == AW'(MAXLEN - 1)) ? '0 : (wp_q + AW'(1));
  assign fill_d = (fill_q == LW'(MAXLEN)) ? fill_q : (fill_q + LW'(1));

  // Reading the slot being written would return the stale word. That
  // happens exactly when L = 1, and then the word wanted is `in` itself.
  assign byp_d  = (ra == wp_q);

  // Fewer words written than the delay length: the addressed slot holds
  // leftover data from before reset, so the output is forced to zero.
  assign zero_d = (fill_d < l_eff);

  assign out_d = zero_q ? '0 : (byp_q ? in_q : signed'(rd_data));

  sdp_bram #(
    .WIDTH  (WIDTH),
    .DEPTH  (MAXLEN),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (tick_en),
    .waddr_i (wp_q),
    .wdata_i (in),
    .re_i    (tick_en),
    .raddr_i (ra),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sc_q   <= 1'b1;
      wp_q   <= '0;
      fill_q <= '0;
      upd_q  <= 1'b0;
      byp_q  <= 1'b0;
      zero_q <= 1'b1;
      in_q   <= '0;
      out_q  <= '0;
    end else begin
      sc_q  <= sample_clk;
      upd_q <= tick_en;
      if (tick_en) begin
        wp_q   <= wp_d;
        fill_q <= fill_d;
        byp_q  <= byp_d;
        zero_q <= zero_d;
        in_q   <= in;
      end
      if (upd_q) begin
        out_q <= out_d;
      end
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_fifo_delay_bram.sv
// ---------------------------------------------------------------------------
// tb_fifo_delay_bram
//
// Bench for fifo_delay_bram at WIDTH = 32, MAXLEN = 8. The small depth
// makes wrap-around and clamping reachable in a few ticks.
// ---------------------------------------------------------------------------
module tb_fifo_delay_bram;

  localparam int W  = 32;
  localparam int ML = 8;

  logic                clk = 1'b0;
  logic                rstn = 1'b1;
  logic                sample_clk = 1'b0;
  logic                enable = 1'b0;
  logic signed [W-1:0] len = '0;
  logic signed [W-1:0] din = '0;
  logic signed [W-1:0] dout;

  fifo_delay_bram #(
    .WIDTH  (W),
    .MAXLEN (ML)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sample_clk (sample_clk),
    .enable     (enable),
    .len        (len),
    .in         (din),
    .out        (dout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the complete history of accepted samples since the
  // last reset. The output after a tick is the sample L places back from
  // the newest one, or zero if that many samples have not yet arrived.
  int hist[$];
  int exp_out = 0;

  typedef struct {
    logic do_rst;
    logic en;
    int   len;
    int   din;
    int   exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_len(input int l);
    if (l <= 0) return 1;
    if (l > ML) return ML;
    return l;
  endfunction

  function automatic int model_out(input int l);
    int n;
    int le;
    n  = hist.size();
    le = model_len(l);
    return (n >= le) ? hist[n - le] : 0;
  endfunction

  function automatic vec_t mk(input logic r, input logic e, input int l,
                              input int d, input int x);
    vec_t v;
    v.do_rst  = r;
    v.en      = e;
    v.len     = l;
    v.din     = d;
    v.exp_out = x;
    return v;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    hist.delete();
    exp_out = 0;
  endtask

  // One sample tick: sample_clk high for two clk cycles, low for two.
  // mid is out one cycle after the tick edge, when it must not yet have
  // moved. fin is out after the second edge, when it must hold the new value.
  task automatic do_tick(input int d, input int l, input logic en,
                         output int mid, output int fin);
    @(negedge clk);
    din        = d;
    len        = l;
    enable     = en;
    sample_clk = 1'b1;
    @(negedge clk);
    mid = dout;
    @(negedge clk);
    fin = dout;
    sample_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Model-checked tick: the DUT is compared against the history model.
  task automatic step(input string tag, input int d, input int l, input logic en);
    int mid;
    int fin;
    int prev;
    prev = exp_out;
    do_tick(d, l, en, mid, fin);
    if (en) begin
      hist.push_back(d);
      exp_out = model_out(l);
    end
    check($sformatf("%s T+1 hold", tag), mid, prev);
    check($sformatf("%s T+2", tag), fin, exp_out);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mid;
    int fin;
    int prev;
    int fb_in;
    int fb_exp[3];

    // Ramp with len = 3.
    vecs.push_back(mk(1'b1, 1'b1, 3, 1, 0));
    vecs.push_back(mk(1'b0, 1'b1, 3, 2, 0));
    vecs.push_back(mk(1'b0, 1'b1, 3, 3, 1));
    vecs.push_back(mk(1'b0, 1'b1, 3, 4, 2));
    vecs.push_back(mk(1'b0, 1'b1, 3, 5, 3));
    // Minimum length, including the clamped non-positive requests.
    vecs.push_back(mk(1'b1, 1'b1, 1, 7, 7));
    vecs.push_back(mk(1'b0, 1'b1, 1, 9, 9));
    vecs.push_back(mk(1'b0, 1'b1, 0, 11, 11));
    vecs.push_back(mk(1'b0, 1'b1, -5, 13, 13));
    // Enable gating with len = 2.
    vecs.push_back(mk(1'b1, 1'b1, 2, 10, 0));
    vecs.push_back(mk(1'b0, 1'b1, 2, 20, 10));
    vecs.push_back(mk(1'b0, 1'b0, 2, 99, 10));
    vecs.push_back(mk(1'b0, 1'b0, 2, 99, 10));
    vecs.push_back(mk(1'b0, 1'b0, 2, 99, 10));
    vecs.push_back(mk(1'b0, 1'b1, 2, 30, 20));

    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("reset out", dout, 0);

    prev = 0;
    foreach (vecs[i]) begin
      if (vecs[i].do_rst) begin
        pulse_reset();
        check($sformatf("vec%0d reset out", i), dout, 0);
        prev = 0;
      end
      do_tick(vecs[i].din, vecs[i].len, vecs[i].en, mid, fin);
      check($sformatf("vec%0d T+1 hold", i), mid, prev);
      check($sformatf("vec%0d T+2", i), fin, vecs[i].exp_out);
      prev = vecs[i].exp_out;
    end

    // Wrap-around at full depth, then the same run with len clamped from 100.
    pulse_reset();
    for (int k = 0; k < 20; k++) step("wrap len8", k, 8, 1'b1);
    check("wrap len8 final", dout, 12);
    pulse_reset();
    for (int k = 0; k < 20; k++) step("wrap len100", k, 100, 1'b1);
    check("wrap len100 final", dout, 12);

    // Reset mid-stream with a full buffer: the output clears at once, and
    // the stale RAM words stay masked until len new samples have arrived.
    @(posedge clk);
    #2 rstn = 1'b1;
    #1 check("async reset out", dout, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    hist.delete();
    exp_out = 0;
    for (int k = 0; k < 8; k++) step("post-reset", 100 + k, 8, 1'b1);
    check("post-reset first sample", dout, 100);

    // sample_clk held high across reset release must not create a tick.
    @(negedge clk);
    len        = 1;
    din        = 55;
    enable     = 1'b1;
    sample_clk = 1'b1;
    rstn       = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    check("no tick at reset release", dout, 0);
    sample_clk = 1'b0;
    repeat (2) @(negedge clk);
    hist.delete();
    exp_out = 0;
    step("after release", 66, 2, 1'b1);

    // Feedback loop in Q16.16: in = impulse + out/2 with len = 1.
    fb_exp[0] = 65536;
    fb_exp[1] = 32768;
    fb_exp[2] = 16384;
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      fb_in = ((k == 0) ? 65536 : 0) + (int'(dout) >>> 1);
      do_tick(fb_in, 1, 1'b1, mid, fin);
      check($sformatf("feedback tick%0d", k), fin, fb_exp[k]);
    end

    // Randomized: random data, random len (including out-of-range values)
    // and occasional disabled ticks, against the history model.
    pulse_reset();
    for (int k = 0; k < 200; k++) begin
      int l;
      int d;
      logic en;
      l  = int'($urandom_range(15)) - 3;
      d  = int'($urandom);
      en = ($urandom_range(7) != 0);
      step($sformatf("rand%0d", k), d, l, en);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_delay_bram.md
# fifo_delay_bram

Fixed-length sample delay line built on a single block-RAM circular buffer. It presents each sample-rate input word again exactly `len` sample ticks later. It is the delay element inside the reverb's all-pass and comb filters, which close a feedback loop around it, so `out` must never depend combinationally on `in`.

## Interface
- `WIDTH`, default 32: data word width in bits. Two's-complement fixed point, passed through untouched.
- `MAXLEN`, default 4096 (`MAX_FILTER_FIFO_LENGTH`): buffer depth in words, and the maximum delay.
- One clock; reset is asynchronous and active-high.
- `clk` input, 1 bit: system clock; all state is in this domain.
- `rstn` input, 1 bit: asynchronous reset.
  - Active-high despite the name: asserted when `rstn` = 1.
- `sample_clk` input, 1 bit: sample-rate signal, synchronous to `clk`. Each rising edge, as seen in the `clk` domain, is one sample tick.
- `enable` input, 1 bit: when 0, ticks are ignored.
- `len` input, `WIDTH` bits, signed: delay in samples.
- `in` input, `WIDTH` bits, signed: sample to store.
- `out` output, `WIDTH` bits, signed: delayed sample, registered.

## Operation
- **Tick detect:** register `sample_clk` into `sc_q`. `tick` = `sample_clk & ~sc_q`.
- **Effective length:**
  - `L` = 1 if `len` ≤ 0.
  - `L` = `MAXLEN` if `len` > `MAXLEN`.
  - Otherwise `L` = `len`.
  - `L` is sampled at each tick, so a change in `len` takes effect at the next tick.
- **On a tick with `enable` = 1:**
  - Write `mem[wp]` ← `in`.
  - Advance `wp` ← (`wp`+1) mod `MAXLEN`.
  - Increment `fill`, saturating at `MAXLEN`.
- **Read address:** `ra` = (`wp` + 1 − `L`) mod `MAXLEN`, using the pre-increment `wp`.
  - Contract: after tick k, which captures x[k], `out` = x[k+1−L].
  - With `L` = 1, `out` = x[k], the word just written.
- **Bypass:** when `ra` == `wp` (always true for `L` = 1), `out` takes the written `in` directly. It never reads the stale RAM word.
- **Unwritten data:** when `fill` (after the increment) < `L`, `out` = 0. The RAM is never cleared; `fill` alone masks unwritten data.
- **Wrap-around:** modular address arithmetic. `MAXLEN` need not be a power of two, so use compare-and-subtract, not a bit mask.
- **`enable` = 0:** no write, no pointer or `fill` change, `out` holds.

## Timing
- **Reset values:** `out` = 0, `wp` = 0, `fill` = 0. `sc_q` resets to 1, so a `sample_clk` that is high at reset release does not produce a tick.
- **Tick timing:** the tick is detected in cycle T, the first `clk` edge at which `sample_clk` is seen high after being low.
  - The RAM write and the read-address register are issued at the end of cycle T.
  - The synchronous RAM read data appear in T+1.
  - `out` updates at the clock edge ending T+1, so it is valid from T+2.
  - Latency is 2 `clk` cycles; `out` then holds until the next tick's update.
- **Sample rate limit:** `sample_clk` high and low phases must each be ≥ 2 `clk` cycles, giving a minimum tick spacing of 4 `clk` cycles.
  - Consumers may sample `out` on the next `sample_clk` rising edge.
- **Reset during operation:** asynchronously returns to the reset values. RAM contents are ignored because `fill` = 0.
- **Simultaneous events:** a tick coinciding with a `len` change uses the new `len`. A tick coinciding with the `enable` 1→0 transition is dropped.

## Structure
- **Shared package `delay_pkg`:**
  - `MAX_FILTER_FIFO_LENGTH`.
  - Function `clamp_len`.
  - `ADDR_W` = `$clog2(MAXLEN)`.
- **One sub-module, `sdp_bram`:** simple dual-port RAM with one write and one registered read port, inferable as block RAM.
- The top level holds the pointers, `fill`, edge detect, bypass and zero mask.

## Test plan
- **Reset, then ramp:** `len` = 3, feed 1, 2, 3, 4, 5 on ticks 0–4. `out` after each tick = 0, 0, 1, 2, 3, each valid at T+2.
- **Minimum length:** `len` = 1 feeding 7, then 9: `out` = 7, then 9. `len` = 0 or −5 behaves identically.
- **Wrap-around at `MAXLEN` = 8:**
  - `len` = 8: after 20 ticks of input k, `out` = 12.
  - `len` = 100 is clamped to 8 and gives the same result.
- **Enable gating:** `len` = 2, inputs 10, 20, then `enable` = 0 for 3 ticks with input 99. `out` holds at 10 and `wp` is unchanged; after re-enabling with input 30, `out` = 20.
- **Reset mid-stream:** with a full buffer, pulse `rstn` high. `out` = 0 immediately and stays 0 for the first `len` − 1 ticks.
- **Feedback loop:** wrap with `add0` = `in` + (`out` >>> 1), `len` = 1, impulse 1.0 then zeros. Expect `out` 1.0, 0.5, 0.25 on successive ticks; no combinational loop is reported by lint.
